// File: rtl/io_bank_pkg.sv
// Shared register map, bit positions and UART FSM state type for io_bank.
package io_bank_pkg;

  localparam logic [7:0] IO_GPIO_OUT    = 8'h00;
  localparam logic [7:0] IO_GPIO_IN     = 8'h04;
  localparam logic [7:0] IO_TIMER_COUNT = 8'h08;
  localparam logic [7:0] IO_TIMER_CMP   = 8'h0C;
  localparam logic [7:0] IO_TIMER_CTRL  = 8'h10;
  localparam logic [7:0] IO_UART_TX     = 8'h14;
  localparam logic [7:0] IO_UART_STATUS = 8'h18;
  localparam logic [7:0] IO_UART_BAUD   = 8'h1C;

  localparam int unsigned CTRL_EN   = 0;
  localparam int unsigned CTRL_AR   = 1;
  localparam int unsigned CTRL_PEND = 2;

  localparam int unsigned STAT_FULL  = 0;
  localparam int unsigned STAT_EMPTY = 1;
  localparam int unsigned STAT_BUSY  = 2;
  localparam int unsigned STAT_OVF   = 3;

  typedef enum logic [1:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_STOP
  } uart_state_t;

endpackage

// File: rtl/io_uart_tx.sv
// UART 8N1 transmitter: TX FIFO, baud counter and shifter FSM.
module io_uart_tx
  import io_bank_pkg::*;
#(
  parameter int unsigned TX_DEPTH     = 4,
  parameter int unsigned TX_DEPTH_LOG = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic [7:0]  push_data,
  input  logic [15:0] div,
  output logic        full,
  output logic        empty,
  output logic        busy,
  output logic        overflow_set,
  output logic        tx
);

  localparam logic [TX_DEPTH_LOG-1:0] PTR_ONE  = 1;
  localparam logic [TX_DEPTH_LOG:0]   CNT_ONE  = 1;
  localparam logic [TX_DEPTH_LOG:0]   CNT_FULL = (TX_DEPTH_LOG+1)'(TX_DEPTH);

  logic [7:0]              r_mem [TX_DEPTH];
  logic [TX_DEPTH_LOG-1:0] r_wptr;
  logic [TX_DEPTH_LOG-1:0] r_rptr;
  logic [TX_DEPTH_LOG:0]   r_cnt;
  uart_state_t             r_state;
  uart_state_t             w_state_nx;
  logic [15:0]             r_baud_cnt;
  logic [15:0]             r_div;
  logic [2:0]              r_bit;
  logic [7:0]              r_shift;
  logic                    w_pop;
  logic                    w_push_ok;
  logic                    w_bit_end;

  assign full         = (r_cnt == CNT_FULL);
  assign empty        = (r_cnt == '0);
  assign busy         = (r_state != UART_IDLE);
  assign w_bit_end    = (r_baud_cnt == r_div);
  assign w_push_ok    = push && (!full || w_pop);
  assign overflow_set = push && full && !w_pop;

  always_comb begin
    w_state_nx = r_state;
    w_pop      = 1'b0;
    tx         = 1'b1;
    case (r_state)
      UART_IDLE: begin
        if (!empty) begin
          w_pop      = 1'b1;
          w_state_nx = UART_START;
        end
      end
      UART_START: begin
        tx = 1'b0;
        if (w_bit_end) w_state_nx = UART_DATA;
      end
      UART_DATA: begin
        tx = r_shift[0];
        if (w_bit_end && (r_bit == 3'd7)) w_state_nx = UART_STOP;
      end
      UART_STOP: begin
        if (w_bit_end) begin
          // Chain straight into the next START so frames have no idle gap.
          if (!empty) begin
            w_pop      = 1'b1;
            w_state_nx = UART_START;
          end else begin
            w_state_nx = UART_IDLE;
          end
        end
      end
      default: w_state_nx = UART_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= UART_IDLE;
    else       r_state <= w_state_nx;
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_cnt      <= '0;
      r_baud_cnt <= '0;
      r_div      <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)     r_rptr <= r_rptr + PTR_ONE;
      if (w_push_ok && !w_pop)      r_cnt <= r_cnt + CNT_ONE;
      else if (!w_push_ok && w_pop) r_cnt <= r_cnt - CNT_ONE;
      // The divider is latched per bit so BAUD writes apply at the next boundary.
      if (w_pop) begin
        r_shift    <= r_mem[r_rptr];
        r_baud_cnt <= '0;
        r_div      <= div;
        r_bit      <= '0;
      end else if (r_state != UART_IDLE) begin
        if (w_bit_end) begin
          r_baud_cnt <= '0;
          r_div      <= div;
          if (r_state == UART_DATA) begin
            r_shift <= {1'b0, r_shift[7:1]};
            r_bit   <= r_bit + 3'd1;
          end
        end else begin
          r_baud_cnt <= r_baud_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: rtl/io_bank.sv
// Memory-mapped I/O bank: GPIO, compare timer with interrupt, UART TX.
module io_bank
  import io_bank_pkg::*;
#(
  parameter int unsigned GPIO_W       = 8,
  parameter int unsigned TX_DEPTH     = 4,
  parameter int unsigned TX_DEPTH_LOG = 2,
  parameter logic [15:0] BAUD_DIV_RST = 16'd103
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        io_addr,
  input  logic              io_en,
  input  logic              io_we,
  input  logic [31:0]       io_data_write,
  output logic [31:0]       io_data_read,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              uart_tx,
  output logic              irq
);

  logic [GPIO_W-1:0] r_gpio_out;
  logic [GPIO_W-1:0] r_gsync1;
  logic [GPIO_W-1:0] r_gsync2;
  logic [31:0]       r_count;
  logic [31:0]       r_cmp;
  logic              r_en;
  logic              r_ar;
  logic              r_pend;
  logic              r_ovf;
  logic [15:0]       r_baud;
  logic [7:0]        w_sel;
  logic              w_wr;
  logic              w_match;
  logic              w_full;
  logic              w_empty;
  logic              w_busy;
  logic              w_ovf_set;
  logic              w_unused;

  assign w_sel    = {io_addr[7:2], 2'b00};
  assign w_unused = ^io_addr[1:0];
  assign w_wr     = io_en && io_we;
  assign w_match  = r_en && (r_count == r_cmp);
  assign gpio_out = r_gpio_out;
  assign irq      = r_pend;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_gpio_out <= '0;
      r_gsync1   <= '0;
      r_gsync2   <= '0;
      r_baud     <= BAUD_DIV_RST;
      r_ovf      <= 1'b0;
    end else begin
      r_gsync1 <= gpio_in;
      r_gsync2 <= r_gsync1;
      if (w_wr && (w_sel == IO_GPIO_OUT))  r_gpio_out <= io_data_write[GPIO_W-1:0];
      if (w_wr && (w_sel == IO_UART_BAUD)) r_baud     <= io_data_write[15:0];
      if (w_ovf_set) r_ovf <= 1'b1;
      else if (w_wr && (w_sel == IO_UART_STATUS) && io_data_write[STAT_OVF]) r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      r_cmp   <= '1;
      r_en    <= 1'b0;
      r_ar    <= 1'b0;
      r_pend  <= 1'b0;
    end else begin
      if (w_wr && (w_sel == IO_TIMER_COUNT)) r_count <= io_data_write;
      else if (r_en) r_count <= (w_match && r_ar) ? '0 : r_count + 32'd1;
      if (w_wr && (w_sel == IO_TIMER_CMP)) r_cmp <= io_data_write;
      if (w_wr && (w_sel == IO_TIMER_CTRL)) begin
        r_en <= io_data_write[CTRL_EN];
        r_ar <= io_data_write[CTRL_AR];
      end
      if (w_match) r_pend <= 1'b1;
      else if (w_wr && (w_sel == IO_TIMER_CTRL) && io_data_write[CTRL_PEND]) r_pend <= 1'b0;
    end
  end

  always_comb begin
    io_data_read = '0;
    if (io_en) begin
      case (w_sel)
        IO_GPIO_OUT:    io_data_read[GPIO_W-1:0] = r_gpio_out;
        IO_GPIO_IN:     io_data_read[GPIO_W-1:0] = r_gsync2;
        IO_TIMER_COUNT: io_data_read = r_count;
        IO_TIMER_CMP:   io_data_read = r_cmp;
        IO_TIMER_CTRL: begin
          io_data_read[CTRL_EN]   = r_en;
          io_data_read[CTRL_AR]   = r_ar;
          io_data_read[CTRL_PEND] = r_pend;
        end
        IO_UART_STATUS: begin
          io_data_read[STAT_FULL]  = w_full;
          io_data_read[STAT_EMPTY] = w_empty;
          io_data_read[STAT_BUSY]  = w_busy;
          io_data_read[STAT_OVF]   = r_ovf;
        end
        IO_UART_BAUD:   io_data_read[15:0] = r_baud;
        default:        io_data_read = '0;
      endcase
    end
  end

  io_uart_tx #(
    .TX_DEPTH     (TX_DEPTH),
    .TX_DEPTH_LOG (TX_DEPTH_LOG)
  ) u_uart_tx (
    .clk          (clk),
    .reset        (reset),
    .push         (w_wr && (w_sel == IO_UART_TX)),
    .push_data    (io_data_write[7:0]),
    .div          (r_baud),
    .full         (w_full),
    .empty        (w_empty),
    .busy         (w_busy),
    .overflow_set (w_ovf_set),
    .tx           (uart_tx)
  );

endmodule

// File: tb/tb_io_bank.sv
module tb_io_bank;
  import io_bank_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  io_addr;
  logic        io_en;
  logic        io_we;
  logic [31:0] io_data_write;
  logic [31:0] io_data_read;
  logic [7:0]  gpio_in;
  logic [7:0]  gpio_out;
  logic        uart_tx;
  logic        irq;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  always #5 clk = ~clk;

  io_bank #(
    .GPIO_W       (8),
    .TX_DEPTH     (4),
    .TX_DEPTH_LOG (2),
    .BAUD_DIV_RST (16'd103)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .io_addr       (io_addr),
    .io_en         (io_en),
    .io_we         (io_we),
    .io_data_write (io_data_write),
    .io_data_read  (io_data_read),
    .gpio_in       (gpio_in),
    .gpio_out      (gpio_out),
    .uart_tx       (uart_tx),
    .irq           (irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called just after a negedge; the write commits at the following posedge.
  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    io_addr       = a;
    io_data_write = d;
    io_we         = 1'b1;
    io_en         = 1'b1;
    @(negedge clk);
    io_en = 1'b0;
    io_we = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] d;
    io_addr = a;
    io_we   = 1'b0;
    io_en   = 1'b1;
    #1;
    d     = io_data_read;
    io_en = 1'b0;
    check(tag, d, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rst_exp [8];
    logic [7:0]  bytes [6];
    logic [9:0]  frame;
    logic        exp_bit;
    int          f;
    int          b;

    rst_exp = '{32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h2, 32'd103};
    bytes   = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

    reset = 1'b1; io_en = 1'b0; io_we = 1'b0; io_addr = '0; io_data_write = '0; gpio_in = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) rd_chk($sformatf("rst_rd_%0h", i * 4), 8'(i * 4), rst_exp[i]);
    check("rst_tx", 32'(uart_tx), 32'd1);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_gpio_out", 32'(gpio_out), 32'd0);

    wr(8'h20, 32'hDEAD_BEEF);
    rd_chk("unmapped", 8'h20, 32'h0);
    io_addr = IO_UART_BAUD; io_en = 1'b0; #1;
    check("rd_no_en", io_data_read, 32'h0);

    // GPIO
    wr(IO_GPIO_OUT, 32'hFFFF_FFA5);
    check("gpio_out", 32'(gpio_out), 32'hA5);
    rd_chk("gpio_out_rd", IO_GPIO_OUT, 32'hA5);
    gpio_in = 8'h3C;
    rd_chk("gpio_in_0edge", IO_GPIO_IN, 32'h0);
    @(negedge clk);
    rd_chk("gpio_in_1edge", IO_GPIO_IN, 32'h0);
    @(negedge clk);
    rd_chk("gpio_in_2edge", IO_GPIO_IN, 32'h3C);

    // Timer
    wr(IO_TIMER_COUNT, 32'h1234_5678);
    rd_chk("cnt_wr", IO_TIMER_COUNT, 32'h1234_5678);
    wr(IO_TIMER_COUNT, 32'h0);
    wr(IO_TIMER_CMP, 32'd5);
    wr(IO_TIMER_CTRL, 32'h3);
    rd_chk("cnt_start", IO_TIMER_COUNT, 32'd0);
    repeat (5) @(negedge clk);
    rd_chk("cnt_at_cmp", IO_TIMER_COUNT, 32'd5);
    check("irq_before", 32'(irq), 32'd0);
    @(negedge clk);
    check("irq_rise", 32'(irq), 32'd1);
    rd_chk("cnt_reload", IO_TIMER_COUNT, 32'd0);
    rd_chk("ctrl_pend", IO_TIMER_CTRL, 32'h7);
    wr(IO_TIMER_CTRL, 32'h7);
    check("irq_clear", 32'(irq), 32'd0);
    rd_chk("ctrl_after_clr", IO_TIMER_CTRL, 32'h3);
    wr(IO_TIMER_CTRL, 32'h0);

    // UART single frame
    wr(IO_UART_BAUD, 32'd3);
    rd_chk("baud_rd", IO_UART_BAUD, 32'd3);
    wr(IO_UART_TX, 32'h55);
    rd_chk("stat_queued", IO_UART_STATUS, 32'h0);
    check("tx_idle_pre", 32'(uart_tx), 32'd1);
    frame = {1'b1, 8'h55, 1'b0};
    for (int bi = 0; bi < 10; bi++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        check($sformatf("tx55_b%0d_c%0d", bi, c), 32'(uart_tx), 32'(frame[bi]));
        if (bi == 0 && c == 0) rd_chk("stat_busy", IO_UART_STATUS, 32'h6);
      end
    end
    @(negedge clk);
    check("tx_idle_post", 32'(uart_tx), 32'd1);
    rd_chk("stat_idle", IO_UART_STATUS, 32'h2);

    // Back-to-back burst with overflow; s counts negedges after the first pop edge
    for (int i = 0; i < 6; i++) wr(IO_UART_TX, 32'(bytes[i]));
    for (int s = 4; s <= 204; s++) begin
      if (s < 200) begin
        f = s / 40;
        b = (s % 40) / 4;
        if (b == 0)      exp_bit = 1'b0;
        else if (b == 9) exp_bit = 1'b1;
        else             exp_bit = bytes[f][b-1];
      end else begin
        exp_bit = 1'b1;
      end
      check($sformatf("burst_s%0d", s), 32'(uart_tx), 32'(exp_bit));
      if (s == 4) rd_chk("stat_ovf", IO_UART_STATUS, 32'hD);
      if (s == 10) begin
        io_addr = IO_UART_STATUS; io_data_write = 32'h8; io_we = 1'b1; io_en = 1'b1;
      end
      if (s == 11) begin
        io_en = 1'b0; io_we = 1'b0;
      end
      if (s == 12) rd_chk("stat_ovf_clr", IO_UART_STATUS, 32'h5);
      if (s != 204) @(negedge clk);
    end
    rd_chk("stat_burst_end", IO_UART_STATUS, 32'h2);

    // Reset mid-frame
    wr(IO_UART_TX, 32'hF0);
    wr(IO_UART_TX, 32'h0F);
    wr(IO_UART_TX, 32'h81);
    repeat (8) @(negedge clk);
    check("tx_mid_data", 32'(uart_tx), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("tx_after_rst", 32'(uart_tx), 32'd1);
    rd_chk("stat_after_rst", IO_UART_STATUS, 32'h2);
    rd_chk("baud_after_rst", IO_UART_BAUD, 32'd103);
    check("gpio_after_rst", 32'(gpio_out), 32'd0);
    repeat (3) @(negedge clk);
    check("tx_stays_idle", 32'(uart_tx), 32'd1);

    wr(IO_UART_BAUD, 32'd3);
    wr(IO_UART_TX, 32'hA3);
    rd_chk("stat_resume_q", IO_UART_STATUS, 32'h0);
    @(negedge clk);
    check("tx_resume_start", 32'(uart_tx), 32'd0);
    rd_chk("stat_resume_busy", IO_UART_STATUS, 32'h6);
    repeat (4) @(negedge clk);
    check("tx_resume_b0", 32'(uart_tx), 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
